// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the divider scheduler: FSM state encoding,
// debug view struct and a small modular-increment helper.
package div_sched_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // rr_ptr is sized for the largest supported requester count (8).
  typedef struct packed {
    state_t     state;
    logic [2:0] rr_ptr;
    logic       div_busy;
  } dbg_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/div_sched_if.sv
// Requester and divider-side signals of the scheduler, bundled into one interface.
// Handshake: a request transfers in the cycle req_valid[i] & req_ready[i]; resp_valid,
// div_i_valid and div_o_valid are single-cycle strobes with no back-pressure.
interface div_sched_if #(
  parameter int NUM_REQ = div_sched_pkg::DEF_NUM_REQ,
  parameter int WIDTH   = div_sched_pkg::DEF_WIDTH
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_dividend;
  logic [NUM_REQ*WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]       req_ready;

  logic                     resp_valid;
  logic [IDW-1:0]           resp_id;
  logic [WIDTH-1:0]         resp_q;
  logic [WIDTH-1:0]         resp_rem;
  logic                     resp_err;

  logic                     div_i_valid;
  logic [WIDTH-1:0]         div_dividend;
  logic [WIDTH-1:0]         div_divisor;
  logic                     div_busy;
  logic [WIDTH-1:0]         div_q;
  logic [WIDTH-1:0]         div_rem;
  logic                     div_o_valid;

  // master: requesters plus the divider; slave: the scheduler itself.
  modport master (
    output req_valid, req_dividend, req_divisor,
    input  req_ready,
    input  resp_valid, resp_id, resp_q, resp_rem, resp_err,
    input  div_i_valid, div_dividend, div_divisor,
    output div_busy, div_q, div_rem, div_o_valid
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    output req_ready,
    output resp_valid, resp_id, resp_q, resp_rem, resp_err,
    output div_i_valid, div_dividend, div_divisor,
    input  div_busy, div_q, div_rem, div_o_valid
  );

endinterface

// File: rtl/div_sched_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  logic [IW:0] cand;
  logic        found;

  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found               = 1'b1;
        grant[cand[IW-1:0]] = 1'b1;
        idx                 = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/div_sched.sv
// Shares one iterative divider among NUM_REQ requesters: round-robin grant,
// one outstanding division, divide-by-zero answered locally without the divider.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  div_sched_if.slave  bus,
  output dbg_t        dbg
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     cur_id;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               any_req;
  logic [WIDTH-1:0]   sel_dividend;
  logic [WIDTH-1:0]   sel_divisor;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign any_req      = |bus.req_valid;
  assign sel_dividend = bus.req_dividend[grant_idx*WIDTH +: WIDTH];
  assign sel_divisor  = bus.req_divisor[grant_idx*WIDTH +: WIDTH];

  // Accept only in IDLE, and never while reset is held even though IDLE is forced.
  assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;

  assign dbg = '{state: state, rr_ptr: 3'(rr_ptr), div_busy: bus.div_busy};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      cur_id           <= '0;
      bus.resp_valid   <= 1'b0;
      bus.resp_id      <= '0;
      bus.resp_q       <= '0;
      bus.resp_rem     <= '0;
      bus.resp_err     <= 1'b0;
      bus.div_i_valid  <= 1'b0;
      bus.div_dividend <= '0;
      bus.div_divisor  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            rr_ptr <= IDW'(wrap_inc(int'(grant_idx), NUM_REQ));
            cur_id <= grant_idx;
            if (sel_divisor == '0) begin
              bus.resp_valid <= 1'b1;
              bus.resp_id    <= grant_idx;
              bus.resp_q     <= '1;
              bus.resp_rem   <= sel_dividend;
              bus.resp_err   <= 1'b1;
              state          <= RESP;
            end else begin
              bus.div_i_valid  <= 1'b1;
              bus.div_dividend <= sel_dividend;
              bus.div_divisor  <= sel_divisor;
              state            <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.div_i_valid <= 1'b0;
          state           <= WAIT;
        end
        WAIT: begin
          if (bus.div_o_valid) begin
            bus.resp_valid <= 1'b1;
            bus.resp_id    <= cur_id;
            bus.resp_q     <= bus.div_q;
            bus.resp_rem   <= bus.div_rem;
            bus.resp_err   <= 1'b0;
            state          <= RESP;
          end
        end
        RESP: begin
          bus.resp_valid <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: directed requests push expected grants, divider
// starts and responses; a negedge monitor pops and compares them.
module tb_div_sched;
  import div_sched_pkg::*;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int DIV_LAT = 3;
  localparam int EW      = 23;
  localparam int TMO     = 300;

  logic clk = 1'b0;
  logic rst;
  dbg_t dbg;

  div_sched_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  div_sched #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .dbg (dbg)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int accept_cnt = 0;

  // {id[1:0], q[7:0], rem[7:0], err, latency[3:0]}
  logic [EW-1:0] exp_q[$];
  logic [1:0]    exp_grant_q[$];
  logic [15:0]   exp_div_q[$];
  int            acc_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s at t=%0t", name, why, $time);
  endtask

  // Normal latency: accept, ISSUE, divider strobe DIV_LAT cycles after start, then RESP.
  task automatic expect_txn(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] q, input logic [7:0] r, input logic err);
    exp_grant_q.push_back(id);
    if (!err) exp_div_q.push_back({a, b});
    exp_q.push_back({id, q, r, err, err ? 4'd1 : 4'(2 + DIV_LAT)});
  endtask

  // ---------------- divider model ----------------
  logic       inject = 1'b0;
  int         cnt    = 0;
  logic [7:0] ma, mb;

  initial begin
    bus.div_o_valid = 1'b0;
    bus.div_busy    = 1'b0;
    bus.div_q       = '0;
    bus.div_rem     = '0;
    ma = '0;
    mb = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.div_o_valid = 1'b0;
      if (rst) begin
        cnt          = 0;
        bus.div_busy = 1'b0;
      end else if (inject) begin
        bus.div_o_valid = 1'b1;
        bus.div_q       = 8'hAA;
        bus.div_rem     = 8'h55;
        inject          = 1'b0;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.div_o_valid = 1'b1;
          bus.div_q       = (mb == 0) ? 8'hFF : ma / mb;
          bus.div_rem     = (mb == 0) ? ma : ma % mb;
          bus.div_busy    = 1'b0;
        end
      end else if (bus.div_i_valid) begin
        ma           = bus.div_dividend;
        mb           = bus.div_divisor;
        cnt          = DIV_LAT;
        bus.div_busy = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] mon_e;
  logic [1:0]    mon_g;
  logic [15:0]   mon_d;
  logic [3:0]    mon_oh;
  int            mon_acc;

  always @(negedge clk) begin
    if (!rst) begin
      if (|(bus.req_valid & bus.req_ready)) begin
        accept_cnt++;
        acc_cyc_q.push_back(cyc);
        if (exp_grant_q.size() == 0) begin
          fail("grant", $sformatf("unexpected accept, req_ready=0x%0h", bus.req_ready));
        end else begin
          mon_g  = exp_grant_q.pop_front();
          mon_oh = 4'b0001 << mon_g;
          chk("grant", 32'(bus.req_ready), 32'(mon_oh));
        end
      end
      if (bus.div_i_valid) begin
        if (exp_div_q.size() == 0) begin
          fail("div_start", $sformatf("unexpected div_i_valid, operands %0d/%0d",
                                      bus.div_dividend, bus.div_divisor));
        end else begin
          mon_d = exp_div_q.pop_front();
          chk("div_dividend", 32'(bus.div_dividend), 32'(mon_d[15:8]));
          chk("div_divisor", 32'(bus.div_divisor), 32'(mon_d[7:0]));
        end
      end
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          fail("resp", $sformatf("unexpected resp_valid id=%0d q=%0d rem=%0d",
                                 bus.resp_id, bus.resp_q, bus.resp_rem));
        end else begin
          mon_e   = exp_q.pop_front();
          mon_acc = (acc_cyc_q.size() != 0) ? acc_cyc_q.pop_front() : -100;
          chk("resp_id", 32'(bus.resp_id), 32'(mon_e[22:21]));
          chk("resp_q", 32'(bus.resp_q), 32'(mon_e[20:13]));
          chk("resp_rem", 32'(bus.resp_rem), 32'(mon_e[12:5]));
          chk("resp_err", 32'(bus.resp_err), 32'(mon_e[4]));
          chk("resp_latency", 32'(cyc - mon_acc), 32'(mon_e[3:0]));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int id, input logic [7:0] a, input logic [7:0] b);
    int  n;
    bit  done;
    @(posedge clk);
    #1;
    bus.req_dividend[id*W +: W] = a;
    bus.req_divisor[id*W +: W]  = b;
    bus.req_valid[id]           = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        done = 1'b1;
      end else if (++n > TMO) begin
        fail("accept_timeout", $sformatf("requester %0d never accepted", id));
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_grant_q.size() != 0 || exp_div_q.size() != 0) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) fail("drain", "expected transactions still pending");
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
    chk({tag, "_resp_err"}, 32'(bus.resp_err), 0);
    chk({tag, "_resp_id"}, 32'(bus.resp_id), 0);
    chk({tag, "_resp_q"}, 32'(bus.resp_q), 0);
    chk({tag, "_resp_rem"}, 32'(bus.resp_rem), 0);
    chk({tag, "_div_i_valid"}, 32'(bus.div_i_valid), 0);
    chk({tag, "_div_dividend"}, 32'(bus.div_dividend), 0);
    chk({tag, "_div_divisor"}, 32'(bus.div_divisor), 0);
    chk({tag, "_rr_ptr"}, 32'(dbg.rr_ptr), 0);
    chk({tag, "_state"}, 32'(dbg.state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int n;

    // All four requesters hold 20/3 from reset onwards.
    rst              = 1'b1;
    bus.req_dividend = {N{8'd20}};
    bus.req_divisor  = {N{8'd3}};
    bus.req_valid    = '1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");

    foreach (order[i]) expect_txn(2'(order[i]), 8'd20, 8'd3, 8'd6, 8'd2, 1'b0);
    rst = 1'b0;
    n = 0;
    while (accept_cnt < 5 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (accept_cnt < 5) fail("sweep", "fewer than five accepts");
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    drain();
    chk("rr_ptr_after_sweep", 32'(dbg.rr_ptr), 1);

    // 100/7 from requester 1.
    expect_txn(2'd1, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    drive(1, 8'd100, 8'd7);
    drain();

    // Divide by zero from requester 2: answered locally.
    expect_txn(2'd2, 8'd55, 8'd0, 8'hFF, 8'd55, 1'b1);
    drive(2, 8'd55, 8'd0);
    drain();
    chk("rr_ptr_after_req2", 32'(dbg.rr_ptr), 3);

    // rr_ptr = 3 with requesters 1 and 3 pending: 3 wins first, 1 stays pending.
    expect_txn(2'd3, 8'd45, 8'd6, 8'd7, 8'd3, 1'b0);
    expect_txn(2'd1, 8'd17, 8'd5, 8'd3, 8'd2, 1'b0);
    fork
      drive(3, 8'd45, 8'd6);
      drive(1, 8'd17, 8'd5);
    join
    drain();
    chk("rr_ptr_after_pair", 32'(dbg.rr_ptr), 2);

    // Dividend smaller than divisor.
    expect_txn(2'd0, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    drive(0, 8'd5, 8'd9);
    drain();

    // Stray divider completion while idle must be ignored.
    @(negedge clk);
    inject = 1'b1;
    drain();

    // Requester 3 pulses req_valid only while a division is in flight: never served.
    expect_txn(2'd0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
    fork
      drive(0, 8'd50, 8'd5);
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.req_dividend[3*W +: W] = 8'd99;
        bus.req_divisor[3*W +: W]  = 8'd9;
        bus.req_valid[3]           = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid[3] = 1'b0;
      end
    join
    drain();

    // Reset during WAIT abandons 200/1.
    exp_grant_q.push_back(2'd2);
    exp_div_q.push_back({8'd200, 8'd1});
    drive(2, 8'd200, 8'd1);
    @(posedge clk);
    #1;
    chk("state_before_abort", 32'(dbg.state), 32'(WAIT));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state("abort");
    exp_q.delete();
    acc_cyc_q.delete();
    repeat (4) @(negedge clk);
    rst = 1'b0;

    expect_txn(2'd1, 8'd9, 8'd4, 8'd2, 8'd1, 1'b0);
    drive(1, 8'd9, 8'd4);
    drain();
    chk("rr_ptr_after_restart", 32'(dbg.rr_ptr), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    fail("watchdog", "simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
